// File: rtl/eth_idma_seq_pkg.sv
// Shared types and register map for the eth_idma_wrap register-bus sequencer.
package eth_idma_seq_pkg;

  localparam int unsigned RegAddrW = 32;
  localparam int unsigned RegDataW = 32;
  localparam int unsigned RegStrbW = RegDataW / 8;

  localparam logic [31:0] OffMacLo    = 32'h00;
  localparam logic [31:0] OffMacHi    = 32'h04;
  localparam logic [31:0] OffSrc      = 32'h10;
  localparam logic [31:0] OffDst      = 32'h14;
  localparam logic [31:0] OffLen      = 32'h18;
  localparam logic [31:0] OffSproto   = 32'h1c;
  localparam logic [31:0] OffDproto   = 32'h20;
  localparam logic [31:0] OffReqValid = 32'h38;
  localparam logic [31:0] OffReqReady = 32'h3c;
  localparam logic [31:0] OffRspReady = 32'h40;

  typedef enum logic [3:0] {
    SEQ_IDLE,
    SEQ_MAC_LO,
    SEQ_MAC_HI,
    SEQ_SRC,
    SEQ_DST,
    SEQ_LEN,
    SEQ_SPROTO,
    SEQ_DPROTO,
    SEQ_POLL,
    SEQ_VLD1,
    SEQ_VLD0,
    SEQ_RSPR,
    SEQ_DONE
  } seq_state_e;

  typedef struct packed {
    logic [RegAddrW-1:0] addr;
    logic                write;
    logic [RegDataW-1:0] wdata;
    logic [RegStrbW-1:0] wstrb;
    logic                valid;
  } reg_bus_req_t;

  typedef struct packed {
    logic [RegDataW-1:0] rdata;
    logic                error;
    logic                ready;
  } reg_bus_rsp_t;

endpackage

// File: rtl/eth_idma_reg_sequencer.sv
// Register-bus master that programs one eth_idma_wrap per command: MAC once after reset,
// then SRC/DST/LEN/protocols, polls REQ_READY, pulses REQ_VALID and sets RSP_READY.
module eth_idma_reg_sequencer
  import eth_idma_seq_pkg::*;
#(
  parameter int unsigned RegAw     = 32,
  parameter int unsigned RegDw     = 32,
  parameter logic [47:0] MacAddr   = 48'h2070_9800_1032,
  parameter int unsigned PollLimit = 1024,
  parameter type         reg_req_t = reg_bus_req_t,
  parameter type         reg_rsp_t = reg_bus_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_src_i,
  input  logic [31:0] cmd_dst_i,
  input  logic [31:0] cmd_len_i,
  input  logic [2:0]  cmd_sproto_i,
  input  logic [2:0]  cmd_dproto_i,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o,
  output reg_req_t    reg_req_o,
  input  reg_rsp_t    reg_rsp_i
);

  localparam int unsigned CntW = $clog2(PollLimit + 1);

  seq_state_e       state_q, state_d;
  reg_req_t         req_q, req_d;
  logic [CntW-1:0]  poll_cnt_q, poll_cnt_d;
  logic             mac_cfg_done_q, mac_cfg_done_d;
  logic             err_q, err_d;
  logic             latch_cmd;
  logic [31:0]      src_q, dst_q, len_q;
  logic [2:0]       sproto_q, dproto_q;

  logic [RegAw-1:0] acc_addr;
  logic [RegDw-1:0] acc_wdata;
  logic             acc_write;

  logic             rdy_d, busy_d, done_d, erro_d;
  logic             unused_rdata;

  assign unused_rdata = ^reg_rsp_i.rdata[RegDw-1:1];

  // State register plus every flop that the FSM drives.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= SEQ_IDLE;
      req_q          <= '0;
      poll_cnt_q     <= '0;
      mac_cfg_done_q <= 1'b0;
      err_q          <= 1'b0;
      src_q          <= '0;
      dst_q          <= '0;
      len_q          <= '0;
      sproto_q       <= '0;
      dproto_q       <= '0;
      cmd_ready_o    <= 1'b1;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      poll_cnt_q     <= poll_cnt_d;
      mac_cfg_done_q <= mac_cfg_done_d;
      err_q          <= err_d;
      if (latch_cmd) begin
        src_q    <= cmd_src_i;
        dst_q    <= cmd_dst_i;
        len_q    <= cmd_len_i;
        sproto_q <= cmd_sproto_i;
        dproto_q <= cmd_dproto_i;
      end
      cmd_ready_o <= rdy_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      err_o       <= erro_d;
    end
  end

  // Address/data of the access owned by each state.
  always_comb begin
    acc_addr  = '0;
    acc_wdata = '0;
    acc_write = 1'b1;
    unique case (state_q)
      SEQ_MAC_LO: begin acc_addr = RegAw'(OffMacLo);  acc_wdata = RegDw'(MacAddr[31:0]); end
      SEQ_MAC_HI: begin acc_addr = RegAw'(OffMacHi);  acc_wdata = RegDw'(MacAddr[47:32]); end
      SEQ_SRC:    begin acc_addr = RegAw'(OffSrc);    acc_wdata = RegDw'(src_q); end
      SEQ_DST:    begin acc_addr = RegAw'(OffDst);    acc_wdata = RegDw'(dst_q); end
      SEQ_LEN:    begin acc_addr = RegAw'(OffLen);    acc_wdata = RegDw'(len_q); end
      SEQ_SPROTO: begin acc_addr = RegAw'(OffSproto); acc_wdata = RegDw'(sproto_q); end
      SEQ_DPROTO: begin acc_addr = RegAw'(OffDproto); acc_wdata = RegDw'(dproto_q); end
      SEQ_POLL:   begin acc_addr = RegAw'(OffReqReady); acc_write = 1'b0; end
      SEQ_VLD1:   begin acc_addr = RegAw'(OffReqValid); acc_wdata = RegDw'(1); end
      SEQ_VLD0:   begin acc_addr = RegAw'(OffReqValid); acc_wdata = '0; end
      SEQ_RSPR:   begin acc_addr = RegAw'(OffRspReady); acc_wdata = RegDw'(1); end
      default:    acc_write = 1'b0;
    endcase
  end

  // Next state: each access state spends one idle cycle, then holds valid until ready.
  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    poll_cnt_d     = poll_cnt_q;
    mac_cfg_done_d = mac_cfg_done_q;
    err_d          = err_q;
    latch_cmd      = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (cmd_valid_i) begin
          latch_cmd  = 1'b1;
          err_d      = 1'b0;
          poll_cnt_d = '0;
          if (cmd_len_i == 32'd0) begin
            state_d = SEQ_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = mac_cfg_done_q ? SEQ_SRC : SEQ_MAC_LO;
          end
        end
      end
      SEQ_DONE: state_d = SEQ_IDLE;
      default: begin
        if (!req_q.valid) begin
          req_d.addr  = acc_addr;
          req_d.write = acc_write;
          req_d.wdata = acc_wdata;
          req_d.wstrb = 4'hf;
          req_d.valid = 1'b1;
        end else if (reg_rsp_i.ready) begin
          req_d.valid = 1'b0;
          if (reg_rsp_i.error) begin
            state_d = SEQ_DONE;
            err_d   = 1'b1;
          end else begin
            unique case (state_q)
              SEQ_MAC_LO: state_d = SEQ_MAC_HI;
              SEQ_MAC_HI: begin
                state_d        = SEQ_SRC;
                mac_cfg_done_d = 1'b1;
              end
              SEQ_SRC:    state_d = SEQ_DST;
              SEQ_DST:    state_d = SEQ_LEN;
              SEQ_LEN:    state_d = SEQ_SPROTO;
              SEQ_SPROTO: state_d = SEQ_DPROTO;
              SEQ_DPROTO: state_d = SEQ_POLL;
              SEQ_POLL: begin
                if (reg_rsp_i.rdata[0]) begin
                  state_d = SEQ_VLD1;
                end else begin
                  poll_cnt_d = (poll_cnt_q == CntW'(PollLimit)) ? poll_cnt_q
                                                                : poll_cnt_q + CntW'(1);
                  if (poll_cnt_d == CntW'(PollLimit)) begin
                    state_d = SEQ_DONE;
                    err_d   = 1'b1;
                  end
                end
              end
              SEQ_VLD1:   state_d = SEQ_VLD0;
              SEQ_VLD0:   state_d = SEQ_RSPR;
              SEQ_RSPR:   state_d = SEQ_DONE;
              default:    state_d = SEQ_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // Handshake/status outputs follow the state being entered.
  always_comb begin
    rdy_d  = (state_d == SEQ_IDLE);
    busy_d = !rdy_d;
    done_d = (state_d == SEQ_DONE);
    erro_d = done_d && err_d;
  end

  assign reg_req_o = req_q;

endmodule

// File: tb/tb_eth_idma_reg_sequencer.sv
// Scoreboard bench for eth_idma_reg_sequencer: stimulus queues expected bus accesses and
// done/err events, a negedge monitor pops and compares them as the DUT produces them.
module tb_eth_idma_reg_sequencer;
  import eth_idma_seq_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         cmd_valid_i = 1'b0;
  logic         cmd_ready_o;
  logic [31:0]  cmd_src_i = '0, cmd_dst_i = '0, cmd_len_i = '0;
  logic [2:0]   cmd_sproto_i = '0, cmd_dproto_i = '0;
  logic         done_o, err_o, busy_o;
  reg_bus_req_t reg_req_o;
  reg_bus_rsp_t reg_rsp_i;

  typedef struct { logic [31:0] addr; logic write; logic [31:0] wdata; } acc_t;
  typedef struct { logic err; int lat; } done_t;

  acc_t  exp_acc[$];
  done_t exp_done[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, acc_edge = 0, n_done = 0;
  int poll_done = 0, poll_base = 0, poll_zeros = 0;
  logic        stall_en = 1'b0, err_en = 1'b0;
  logic [31:0] stall_addr = '0, err_addr = '0;

  eth_idma_reg_sequencer #(.PollLimit(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_src_i(cmd_src_i), .cmd_dst_i(cmd_dst_i), .cmd_len_i(cmd_len_i),
    .cmd_sproto_i(cmd_sproto_i), .cmd_dproto_i(cmd_dproto_i),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .reg_req_o(reg_req_o), .reg_rsp_i(reg_rsp_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Slave model: optional stall/error on one address, REQ_READY reads 0 for poll_zeros reads.
  always_comb begin
    reg_rsp_i       = '0;
    reg_rsp_i.ready = !(stall_en && reg_req_o.addr == stall_addr);
    reg_rsp_i.error = reg_req_o.valid && err_en && reg_req_o.addr == err_addr;
    reg_rsp_i.rdata = (reg_req_o.addr == 32'h3c && (poll_done - poll_base) >= poll_zeros)
                      ? 32'd1 : 32'd0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void pa(input logic [31:0] a, input logic w, input logic [31:0] d);
    acc_t e;
    e.addr = a; e.write = w; e.wdata = d;
    exp_acc.push_back(e);
  endfunction

  function automatic void pd(input logic err, input int lat);
    done_t e;
    e.err = err; e.lat = lat;
    exp_done.push_back(e);
  endfunction

  function automatic void push_cfg(input bit mac, input logic [31:0] s, d, l,
                                   input logic [2:0] sp, dp);
    if (mac) begin
      pa(32'h00, 1'b1, 32'h9800_1032);
      pa(32'h04, 1'b1, 32'h0000_2070);
    end
    pa(32'h10, 1'b1, s);
    pa(32'h14, 1'b1, d);
    pa(32'h18, 1'b1, l);
    pa(32'h1c, 1'b1, {29'd0, sp});
    pa(32'h20, 1'b1, {29'd0, dp});
  endfunction

  function automatic void push_tail(input int zeros);
    for (int i = 0; i <= zeros; i++) pa(32'h3c, 1'b0, 32'h0);
    pa(32'h38, 1'b1, 32'h1);
    pa(32'h38, 1'b1, 32'h0);
    pa(32'h40, 1'b1, 32'h1);
  endfunction

  // Monitor: compares completed accesses and done events, plus per-cycle protocol checks.
  logic        stall_prev = 1'b0, rd_prev = 1'b0, done_prev = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  always @(negedge clk_i) begin
    if (rst_i) begin
      stall_prev = 1'b0; rd_prev = 1'b0; done_prev = 1'b0;
    end else begin
      if (rd_prev) poll_done++;
      rd_prev = 1'b0;
      if (done_prev) check("ready_after_done", 32'(cmd_ready_o), 32'd1);
      done_prev = 1'b0;
      check("busy_vs_ready", 32'(busy_o), 32'(!cmd_ready_o));
      if (stall_prev) begin
        check("hold_valid", 32'(reg_req_o.valid), 32'd1);
        check("hold_addr", reg_req_o.addr, prev_addr);
        check("hold_wdata", reg_req_o.wdata, prev_wdata);
      end
      stall_prev = reg_req_o.valid && !reg_rsp_i.ready;
      prev_addr  = reg_req_o.addr;
      prev_wdata = reg_req_o.wdata;
      if (reg_req_o.valid && reg_rsp_i.ready) begin
        if (exp_acc.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_access: got addr 0x%0h write %0d, required none",
                   reg_req_o.addr, reg_req_o.write);
        end else begin
          acc_t e;
          e = exp_acc.pop_front();
          check("acc_addr", reg_req_o.addr, e.addr);
          check("acc_write", 32'(reg_req_o.write), 32'(e.write));
          if (e.write) begin
            check("acc_wdata", reg_req_o.wdata, e.wdata);
            check("acc_wstrb", 32'(reg_req_o.wstrb), 32'hf);
          end
        end
        if (!reg_req_o.write && reg_req_o.addr == 32'h3c) rd_prev = 1'b1;
      end
      if (done_o) begin
        if (exp_done.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got done err=%0d, required none", err_o);
        end else begin
          done_t e;
          e = exp_done.pop_front();
          check("done_err", 32'(err_o), 32'(e.err));
          check("done_latency", 32'(cyc - acc_edge), 32'(e.lat));
        end
        n_done++;
        done_prev = 1'b1;
      end else if (err_o) begin
        n_cmp++; n_err++;
        $display("FAIL err_without_done: got err_o=1 done_o=0, required err_o=0");
      end
    end
  end

  task automatic send_cmd(input logic [31:0] s, d, l, input logic [2:0] sp, dp);
    bit ok;
    ok = 1'b0;
    @(posedge clk_i); #1;
    cmd_src_i = s; cmd_dst_i = d; cmd_len_i = l;
    cmd_sproto_i = sp; cmd_dproto_i = dp;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      if (cmd_ready_o) begin
        acc_edge = cyc + 1;
        ok = 1'b1;
      end
    end
    check("cmd_accepted", 32'(ok), 32'd1);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk_i);
      if (n_done >= target) ok = 1'b1;
    end
    check("done_seen", 32'(ok), 32'd1);
    @(negedge clk_i);
    check("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    // Reset state
    @(negedge clk_i);
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done_err", 32'({done_o, err_o}), 32'd0);
    check("rst_req_valid", 32'(reg_req_o.valid), 32'd0);
    check("rst_req_addr", reg_req_o.addr, 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    // Test 1: first job with MAC config
    push_cfg(1'b1, 32'h0, 32'h0, 32'h40, 3'd0, 3'd5);
    push_tail(0);
    pd(1'b0, 22);
    send_cmd(32'h0, 32'h0, 32'h40, 3'd0, 3'd5);
    wait_done(1);

    // Test 2: second job skips MAC
    push_cfg(1'b0, 32'h1000, 32'h2000, 32'h80, 3'd5, 3'd0);
    push_tail(0);
    pd(1'b0, 18);
    send_cmd(32'h1000, 32'h2000, 32'h80, 3'd5, 3'd0);
    wait_done(2);

    // Test 3: three not-ready polls then ready
    poll_base = poll_done; poll_zeros = 3;
    push_cfg(1'b0, 32'hA0, 32'hB0, 32'h10, 3'd0, 3'd0);
    push_tail(3);
    pd(1'b0, 24);
    send_cmd(32'hA0, 32'hB0, 32'h10, 3'd0, 3'd0);
    wait_done(3);

    // Test 4: poll timeout at limit 4
    poll_base = poll_done; poll_zeros = 1000;
    push_cfg(1'b0, 32'h11, 32'h22, 32'h33, 3'd5, 3'd5);
    for (int i = 0; i < 4; i++) pa(32'h3c, 1'b0, 32'h0);
    pd(1'b1, 18);
    send_cmd(32'h11, 32'h22, 32'h33, 3'd5, 3'd5);
    wait_done(4);
    poll_zeros = 0;

    // Test 5: bus error on DST write
    err_en = 1'b1; err_addr = 32'h14;
    pa(32'h10, 1'b1, 32'h5);
    pa(32'h14, 1'b1, 32'h6);
    pd(1'b1, 4);
    send_cmd(32'h5, 32'h6, 32'h7, 3'd0, 3'd0);
    wait_done(5);
    err_en = 1'b0;

    // Test 6a: zero length aborts without bus traffic
    pd(1'b1, 0);
    send_cmd(32'h1, 32'h2, 32'h0, 3'd0, 3'd0);
    wait_done(6);

    // Test 6b: reset while LEN write is stalled
    stall_en = 1'b1; stall_addr = 32'h18;
    pa(32'h10, 1'b1, 32'h100);
    pa(32'h14, 1'b1, 32'h200);
    send_cmd(32'h100, 32'h200, 32'h300, 3'd0, 3'd0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      if (reg_req_o.valid && reg_req_o.addr == 32'h18) seen = 1'b1;
    end
    check("len_access_stalled", 32'(seen), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    check("async_drop_valid", 32'(reg_req_o.valid), 32'd0);
    check("async_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("acc_queue_at_abort", 32'(exp_acc.size()), 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    stall_en = 1'b0;
    push_cfg(1'b1, 32'h400, 32'h500, 32'h600, 3'd0, 3'd5);
    push_tail(0);
    pd(1'b0, 22);
    send_cmd(32'h400, 32'h500, 32'h600, 3'd0, 3'd5);
    wait_done(7);

    repeat (3) @(negedge clk_i);
    check("done_queue_drained", 32'(exp_done.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
